// File: rtl/switch_pkg.sv
// Shared switch forwarding-path types and constants used by the lookup scheduler.
package switch_pkg;

  localparam int MAC_W  = 48;
  localparam int PORT_W = 3;

  // dst_port value meaning "send to every port".
  localparam logic [PORT_W-1:0] FLOOD_CODE = 3'b111;

  // Scheduler FSM: pick a requester, start the engine, wait for it, answer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Round-robin pointer advance with wrap at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W:0] cand;

  // Scan N positions starting at ptr; the first asserted request wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (!grant_valid && req[cand[IDX_W-1:0]]) begin
        grant_valid               = 1'b1;
        grant_idx                 = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_lookup_sched.sv
// Shares one mac_learning engine between NUM_PORTS ingress parsers.
// One lookup in flight: grant (IDLE) -> ml_en pulse (ISSUE) -> wait for done or
// watchdog (WAIT) -> one-cycle response strobe to the owner (RESP).
// Handshake: a request transfers in the cycle where req_valid[i] & req_ready[i];
// req_valid must be held until then, and req_ready only pulses in IDLE with ml_busy low.
module mac_lookup_sched
  import switch_pkg::*;
#(
  parameter int                NUM_PORTS  = 4,
  parameter int                TIMEOUT    = 64,
  parameter logic [PORT_W-1:0] FLOOD_CODE = switch_pkg::FLOOD_CODE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*MAC_W-1:0] req_src_mac,
  input  logic [NUM_PORTS*MAC_W-1:0] req_dst_mac,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic [NUM_PORTS-1:0]       resp_valid,
  output logic [PORT_W-1:0]          resp_dst_port,
  output logic [PORT_W-1:0]          resp_tag_port,
  output logic                       resp_timeout,
  output logic                       ml_en,
  output logic [MAC_W-1:0]           ml_src_mac,
  output logic [MAC_W-1:0]           ml_dst_mac,
  output logic [PORT_W-1:0]          ml_src_port,
  input  logic                       ml_done,
  input  logic                       ml_busy,
  input  logic [PORT_W-1:0]          ml_dst_port,
  input  logic [PORT_W-1:0]          ml_tag_port,
  output logic [15:0]                timeout_cnt
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [WD_W-1:0]  wd_q;

  logic [NUM_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;

  logic take;
  logic done_hit;
  logic wd_fire;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; all strobes are held low while rst is asserted.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    ml_en      = 1'b0;
    resp_valid = '0;
    take       = 1'b0;
    done_hit   = 1'b0;
    wd_fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid && !ml_busy && !rst) begin
          req_ready = arb_grant;
          take      = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        ml_en   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A real result beats the watchdog when both land in the same cycle.
        if (ml_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          wd_fire = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = NUM_PORTS'(1) << ml_src_port;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready  = '0;
      ml_en      = 1'b0;
      resp_valid = '0;
      take       = 1'b0;
      done_hit   = 1'b0;
      wd_fire    = 1'b0;
    end
  end

  // Request latch, round-robin pointer, watchdog and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      ml_src_mac    <= '0;
      ml_dst_mac    <= '0;
      ml_src_port   <= '0;
      resp_dst_port <= '0;
      resp_tag_port <= '0;
      resp_timeout  <= 1'b0;
      wd_q          <= '0;
      timeout_cnt   <= '0;
    end else begin
      if (take) begin
        ml_src_mac   <= req_src_mac[int'(arb_idx)*MAC_W +: MAC_W];
        ml_dst_mac   <= req_dst_mac[int'(arb_idx)*MAC_W +: MAC_W];
        ml_src_port  <= PORT_W'(arb_idx);
        rr_ptr_q     <= IDX_W'(rr_next(int'(arb_idx), NUM_PORTS));
        resp_timeout <= 1'b0;
      end
      // The counter holds cycles elapsed since ml_en, so the first WAIT cycle reads 1.
      if (ml_en) begin
        wd_q <= WD_W'(1);
      end else if (state_q == WAIT && !done_hit && !wd_fire) begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (done_hit) begin
        resp_dst_port <= ml_dst_port;
        resp_tag_port <= ml_tag_port;
        resp_timeout  <= 1'b0;
      end
      if (wd_fire) begin
        resp_dst_port <= FLOOD_CODE;
        resp_tag_port <= '0;
        resp_timeout  <= 1'b1;
        if (timeout_cnt != 16'hFFFF) begin
          timeout_cnt <= timeout_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_lookup_sched.sv
// Bench for mac_lookup_sched: directed table of single lookups, hand sequences for
// busy/reset/round-robin, then randomized traffic against a transaction-level model.
module tb_mac_lookup_sched;

  localparam int NP = 4;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP*48-1:0]  req_src_mac, req_dst_mac;
  logic [NP-1:0]     req_ready, resp_valid;
  logic [2:0]        resp_dst_port, resp_tag_port;
  logic              resp_timeout;
  logic              ml_en;
  logic [47:0]       ml_src_mac, ml_dst_mac;
  logic [2:0]        ml_src_port;
  logic              ml_done, ml_busy;
  logic [2:0]        ml_dst_port, ml_tag_port;
  logic [15:0]       timeout_cnt;

  // Clock.
  always #5 clk = ~clk;

  mac_lookup_sched #(.NUM_PORTS(NP), .TIMEOUT(TO), .FLOOD_CODE(3'b111)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_src_mac(req_src_mac), .req_dst_mac(req_dst_mac),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_dst_port(resp_dst_port), .resp_tag_port(resp_tag_port), .resp_timeout(resp_timeout),
    .ml_en(ml_en), .ml_src_mac(ml_src_mac), .ml_dst_mac(ml_dst_mac), .ml_src_port(ml_src_port),
    .ml_done(ml_done), .ml_busy(ml_busy), .ml_dst_port(ml_dst_port), .ml_tag_port(ml_tag_port),
    .timeout_cnt(timeout_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Stimulus state: pending lookups per requester, their MACs, engine behaviour.
  int          want [NP];
  logic [47:0] smac [NP];
  logic [47:0] dmac [NP];
  bit          busy_in, rst_in, stray_en;
  int          eng_delay;
  logic [2:0]  eng_dst, eng_tag;
  int          done_at;
  logic [2:0]  done_dst, done_tag;

  // Reference model: lookup timeline as cycle numbers.
  int          m_ptr, m_idle_at, m_en_at, m_resp_at, m_owner, m_cnt;
  bit          m_waiting;
  logic [47:0] m_src, m_dst;
  logic [2:0]  m_rdst, m_rtag;
  bit          m_rto;

  // Observations for the directed tests.
  int          n_ready, n_en, n_resp;
  int          last_ready_cyc, last_en_cyc, last_resp_cyc;
  logic [NP-1:0] last_resp_vec;
  logic [2:0]  last_dst, last_tag, last_src_port;
  bit          last_to;
  int          grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    tests++;
    fails++;
    $display("FAIL %s cyc=%0d actual=no_event required=event", name, cyc);
  endtask

  // One clock cycle: drive inputs, sample at negedge, compare with model, advance model.
  task automatic tick();
    logic [NP-1:0] rv, e_ready, e_resp;
    logic dn;
    logic [2:0] dd, dt;
    bit e_en;
    int g;
    for (int i = 0; i < NP; i++) begin
      rv[i] = (want[i] > 0);
      req_src_mac[48*i +: 48] = smac[i];
      req_dst_mac[48*i +: 48] = dmac[i];
    end
    dn = (cyc == done_at);
    dd = dn ? done_dst : 3'($urandom_range(0, 7));
    dt = dn ? done_tag : 3'($urandom_range(0, 7));
    if (stray_en && !dn && $urandom_range(0, 15) == 0) dn = 1'b1;
    req_valid = rv; ml_busy = busy_in; rst = rst_in;
    ml_done = dn; ml_dst_port = dd; ml_tag_port = dt;
    @(negedge clk);

    e_ready = '0; e_resp = '0; e_en = 1'b0; g = -1;
    if (!rst_in) begin
      if (cyc >= m_idle_at && rv != 0 && !busy_in) begin
        for (int k = 0; k < NP; k++) begin
          int j;
          j = (m_ptr + k) % NP;
          if (g < 0 && rv[j]) g = j;
        end
        e_ready[g] = 1'b1;
      end
      e_en = (cyc == m_en_at);
      if (cyc == m_resp_at) e_resp[m_owner] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("ml_en", 64'(ml_en), 64'(e_en));
    check("resp_valid", 64'(resp_valid), 64'(e_resp));
    if (e_en) begin
      check("ml_src_mac", 64'(ml_src_mac), 64'(m_src));
      check("ml_dst_mac", 64'(ml_dst_mac), 64'(m_dst));
      check("ml_src_port", 64'(ml_src_port), 64'(m_owner));
    end
    if (e_resp != 0) begin
      check("resp_dst_port", 64'(resp_dst_port), 64'(m_rdst));
      check("resp_tag_port", 64'(resp_tag_port), 64'(m_rtag));
      check("resp_timeout", 64'(resp_timeout), 64'(m_rto));
      check("timeout_cnt", 64'(timeout_cnt), 64'(m_cnt));
    end

    // Model advance (uses this cycle's inputs).
    if (rst_in) begin
      m_ptr = 0; m_idle_at = cyc + 1; m_en_at = -1; m_resp_at = -1;
      m_waiting = 0; m_cnt = 0; done_at = -1;
    end else begin
      if (g >= 0) begin
        m_owner = g; m_ptr = (g + 1) % NP; m_en_at = cyc + 1; m_idle_at = 1 << 30;
        m_src = smac[g]; m_dst = dmac[g];
      end
      if (m_waiting) begin
        if (dn) begin
          m_waiting = 0; m_resp_at = cyc + 1; m_rdst = dd; m_rtag = dt; m_rto = 0;
        end else if (cyc - m_en_at == TO - 1) begin
          m_waiting = 0; m_resp_at = cyc + 1; m_rdst = 3'b111; m_rtag = 3'b000; m_rto = 1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (cyc == m_en_at) m_waiting = 1;
      if (cyc == m_resp_at) m_idle_at = cyc + 1;
    end

    // Requester and engine reactions to what the DUT did.
    for (int i = 0; i < NP; i++) begin
      if (req_ready[i] && rv[i]) begin
        n_ready++; last_ready_cyc = cyc; grant_log.push_back(i);
        want[i]--;
        smac[i] = {$urandom(), 16'($urandom())};
        dmac[i] = {$urandom(), 16'($urandom())};
      end
    end
    if (ml_en && !rst_in) begin
      n_en++; last_en_cyc = cyc; last_src_port = ml_src_port;
      done_at = cyc + eng_delay; done_dst = eng_dst; done_tag = eng_tag;
    end
    if (resp_valid != 0) begin
      n_resp++; last_resp_cyc = cyc; last_resp_vec = resp_valid;
      last_dst = resp_dst_port; last_tag = resp_tag_port; last_to = resp_timeout;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_resp(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (n_resp < target && t < budget) begin
      tick();
      t++;
    end
    if (n_resp < target) bound_expired(name);
  endtask

  typedef struct {
    int         port;
    int         delay;
    logic [2:0] edst;
    logic [2:0] etag;
    int         exp_lat;
    logic [2:0] exp_dst;
    logic [2:0] exp_tag;
    bit         exp_to;
    int         exp_inc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base_cnt, r0, t, busy_fall;
    int rr_exp[3];

    // Single-lookup vectors: latency counted from the req_ready cycle.
    vecs[0] = '{2, 5,    3'd1, 3'd4, 7,  3'd1, 3'd4, 1'b0, 0};
    vecs[1] = '{0, 1,    3'd5, 3'd2, 3,  3'd5, 3'd2, 1'b0, 0};
    vecs[2] = '{3, 63,   3'd2, 3'd6, 65, 3'd2, 3'd6, 1'b0, 0};
    vecs[3] = '{1, 64,   3'd4, 3'd3, 65, 3'd7, 3'd0, 1'b1, 1};
    vecs[4] = '{2, 1000, 3'd4, 3'd5, 65, 3'd7, 3'd0, 1'b1, 1};
    vecs[5] = '{1, 62,   3'd1, 3'd1, 64, 3'd1, 3'd1, 1'b0, 0};
    vecs[6] = '{0, 2,    3'd0, 3'd3, 4,  3'd0, 3'd3, 1'b0, 0};
    rr_exp = '{0, 1, 3};

    for (int i = 0; i < NP; i++) begin
      want[i] = 0; smac[i] = '0; dmac[i] = '0;
    end
    busy_in = 0; rst_in = 1; stray_en = 0;
    eng_delay = 3; eng_dst = 0; eng_tag = 0; done_at = -1;
    m_ptr = 0; m_idle_at = 0; m_en_at = -1; m_resp_at = -1; m_owner = 0; m_cnt = 0;
    m_waiting = 0; m_src = '0; m_dst = '0; m_rdst = '0; m_rtag = '0; m_rto = 0;
    n_ready = 0; n_en = 0; n_resp = 0;
    last_ready_cyc = 0; last_en_cyc = 0; last_resp_cyc = 0; last_resp_vec = '0;
    last_dst = '0; last_tag = '0; last_src_port = '0; last_to = 0;

    // Reset and reset-state checks.
    repeat (3) tick();
    rst_in = 0;
    check("rst_ml_src_mac", 64'(ml_src_mac), 64'd0);
    check("rst_ml_dst_mac", 64'(ml_dst_mac), 64'd0);
    check("rst_ml_src_port", 64'(ml_src_port), 64'd0);
    check("rst_resp_dst", 64'(resp_dst_port), 64'd0);
    check("rst_resp_tag", 64'(resp_tag_port), 64'd0);
    check("rst_resp_timeout", 64'(resp_timeout), 64'd0);
    check("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    tick();

    // Directed single-lookup table.
    for (int v = 0; v < 7; v++) begin
      base_cnt = int'(timeout_cnt);
      r0 = n_resp;
      smac[vecs[v].port] = 48'hAAAA_AAAA_AA01 + 48'(v);
      dmac[vecs[v].port] = 48'hBBBB_BBBB_BB02 + 48'(v);
      eng_delay = vecs[v].delay; eng_dst = vecs[v].edst; eng_tag = vecs[v].etag;
      want[vecs[v].port] = 1;
      run_until_resp(r0 + 1, 200, "vec_resp_wait");
      check("vec_en_after_ready", 64'(last_en_cyc - last_ready_cyc), 64'd1);
      check("vec_src_port", 64'(last_src_port), 64'(vecs[v].port));
      check("vec_latency", 64'(last_resp_cyc - last_ready_cyc), 64'(vecs[v].exp_lat));
      check("vec_resp_vec", 64'(last_resp_vec), 64'(1 << vecs[v].port));
      check("vec_dst", 64'(last_dst), 64'(vecs[v].exp_dst));
      check("vec_tag", 64'(last_tag), 64'(vecs[v].exp_tag));
      check("vec_timeout", 64'(last_to), 64'(vecs[v].exp_to));
      check("vec_timeout_cnt", 64'(timeout_cnt), 64'(base_cnt + vecs[v].exp_inc));
      done_at = -1;
      // A late done after the timeout must not produce anything.
      if (vecs[v].exp_to) begin
        r0 = n_resp;
        for (int k = 0; k < 3; k++) begin
          done_at = cyc;
          tick();
        end
        tick(); tick();
        check("late_done_ignored", 64'(n_resp), 64'(r0));
      end
      tick();
    end

    // ml_busy held for 10 cycles with a pending request.
    r0 = n_ready; t = n_en;
    busy_in = 1; want[0] = 1; eng_delay = 3;
    repeat (10) tick();
    check("busy_no_ready", 64'(n_ready), 64'(r0));
    check("busy_no_en", 64'(n_en), 64'(t));
    busy_in = 0; busy_fall = cyc;
    run_until_resp(n_resp + 1, 50, "busy_resp_wait");
    check("busy_grant_at_fall", 64'(last_ready_cyc), 64'(busy_fall));
    check("busy_grant_port", 64'(grant_log[$]), 64'd0);
    tick();

    // Reset while in WAIT: lookup discarded, counter and pointer cleared.
    eng_delay = 1000; want[2] = 1; t = 0;
    while (n_en == 0 || last_src_port != 3'd2 || cyc - last_en_cyc > 20) begin
      if (t > 30) break;
      tick(); t++;
    end
    repeat (5) tick();
    rst_in = 1; tick(); rst_in = 0;
    check("wait_rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    r0 = n_resp;
    repeat (80) tick();
    check("wait_rst_no_resp", 64'(n_resp), 64'(r0));
    grant_log.delete();
    eng_delay = 2; want[0] = 1; want[3] = 1;
    run_until_resp(r0 + 2, 60, "rst_ptr_wait");
    if (grant_log.size() == 2) begin
      check("rst_ptr_first", 64'(grant_log[0]), 64'd0);
      check("rst_ptr_second", 64'(grant_log[1]), 64'd3);
    end else begin
      check("rst_ptr_grants", 64'(grant_log.size()), 64'd2);
    end
    tick();

    // Round robin among ports 0,1,3 starting from pointer 0.
    grant_log.delete();
    want[0] = 4; want[1] = 4; want[3] = 4; eng_delay = 2;
    run_until_resp(n_resp + 12, 300, "rr_wait");
    check("rr_count", 64'(grant_log.size()), 64'd12);
    for (int k = 0; k < grant_log.size() && k < 12; k++) begin
      check("rr_order", 64'(grant_log[k]), 64'(rr_exp[k % 3]));
    end
    tick();

    // Randomized traffic checked cycle by cycle against the model.
    stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 7) == 0 && want[p] < 3) want[p]++;
      if ($urandom_range(0, 60) == 0) want[p] = 0;
      busy_in = ($urandom_range(0, 5) == 0);
      rst_in = ($urandom_range(0, 499) == 0);
      eng_delay = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
      eng_dst = 3'($urandom_range(0, 7));
      eng_tag = 3'($urandom_range(0, 7));
      tick();
    end
    stray_en = 0; busy_in = 0; rst_in = 0;
    for (int i = 0; i < NP; i++) want[i] = 0;
    repeat (80) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
